// File: rtl/input_frame_feeder_if.sv
// AXI-Stream sample input for input_frame_feeder.
// The source drives data/valid/last; the feeder drives ready.
interface input_frame_feeder_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/input_frame_feeder.sv
// Input frame feeder: collects AXI-Stream frames of FRAME_LEN samples into
// two ping-pong banks and replays each complete frame to the first layer as
// a burst of FRAME_LEN back-to-back samples. Short and long frames raise
// frame_err and never reach the layer. A bank is released once the layer
// reports completion through layer_done.
module input_frame_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input_frame_feeder_if.slave   s,
    output logic [DATA_WIDTH-1:0] x_in,
    output logic                  x_valid,
    input  logic                  layer_done,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        WR_FILL,
        WR_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BURST,
        RD_WAIT_DONE
    } rd_state_t;

    logic [DATA_WIDTH-1:0] mem [2][FRAME_LEN];
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CNT_W-1:0]      wr_cnt_next;
    logic [CNT_W-1:0]      rd_cnt;
    wr_state_t             wr_state;
    wr_state_t             wr_state_next;
    rd_state_t             rd_state;
    rd_state_t             rd_state_next;
    logic                  accept;
    logic                  wr_en;
    logic                  set_full;
    logic                  clr_full;
    logic                  err_next;
    logic                  rd_issue;

    // While dropping the tail of a long frame we swallow words regardless of bank state.
    assign s.s_ready = !full[wr_bank] || (wr_state == WR_DROP);
    assign accept    = s.s_valid && s.s_ready;

    // Write side: classify each accepted word as store, frame end, short or long frame.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        wr_state_next = wr_state;
        wr_cnt_next   = wr_cnt;
        wr_en         = 1'b0;
        set_full      = 1'b0;
        err_next      = 1'b0;
        if (accept) begin
            if (wr_state == WR_DROP) begin
                if (s.s_last) begin
                    wr_state_next = WR_FILL;
                end
            end else begin
                wr_en = 1'b1;
                if (wr_cnt == LAST_IDX) begin
                    wr_cnt_next = '0;
                    if (s.s_last) begin
                        set_full = 1'b1;
                    end else begin
                        err_next      = 1'b1;
                        wr_state_next = WR_DROP;
                    end
                end else if (s.s_last) begin
                    err_next    = 1'b1;
                    wr_cnt_next = '0;
                end else begin
                    wr_cnt_next = wr_cnt + 1'b1;
                end
            end
        end
    end

    // Write side state, bank pointer and error pulse.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            wr_state  <= WR_FILL;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_state  <= wr_state_next;
            wr_cnt    <= wr_cnt_next;
            wr_bank   <= wr_bank ^ set_full;
            frame_err <= err_next;
        end
    end

    // Bank storage.
    always_ff @(posedge clk) begin
        // NOTE: the sample memory is deliberately not reset; full flags guard every read.
        if (wr_en) begin
            mem[wr_bank][wr_cnt] <= s.s_data;
        end
    end

    // Full flags: set and clear always target different banks, so both apply in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full[0] <= (full[0] && !(clr_full && !rd_bank)) || (set_full && !wr_bank);
            full[1] <= (full[1] && !(clr_full &&  rd_bank)) || (set_full &&  wr_bank);
        end
    end

    // Read FSM next state: start on a full bank, burst FRAME_LEN reads, wait for the layer.
    always_comb begin
        rd_state_next = rd_state;
        rd_issue      = 1'b0;
        clr_full      = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    rd_state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                rd_issue = 1'b1;
                if (rd_cnt == LAST_IDX) begin
                    rd_state_next = RD_WAIT_DONE;
                end
            end
            RD_WAIT_DONE: begin
                if (layer_done) begin
                    clr_full      = 1'b1;
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // Read FSM registers and registered sample output (one cycle memory read latency).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state  <= RD_IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            x_valid   <= 1'b0;
            x_in      <= '0;
            frame_cnt <= '0;
        end else begin
            rd_state <= rd_state_next;
            rd_bank  <= rd_bank ^ clr_full;
            x_valid  <= rd_issue;
            if (rd_issue) begin
                x_in <= mem[rd_bank][rd_cnt];
                if (rd_cnt == LAST_IDX) begin
                    rd_cnt    <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_frame_feeder.sv
// Directed bench for input_frame_feeder with FRAME_LEN=4, DATA_WIDTH=16.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A monitor collects every issued sample and error pulse.
module tb_input_frame_feeder;

    localparam int DW = 16;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          layer_done = 1'b0;
    logic [DW-1:0] x_in;
    logic          x_valid;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    input_frame_feeder_if #(.DATA_WIDTH(DW)) s_if ();

    input_frame_feeder #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s_if.slave),
        .x_in       (x_in),
        .x_valid    (x_valid),
        .layer_done (layer_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] samples[$];
    int            run = 0;
    int            bad_runs = 0;
    int            err_cycles = 0;
    int            err_cyc = 0;
    int            first_xv_cyc = -1;
    int            last_acc_cyc = 0;
    int            e0;
    int            acc4;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record issued samples, burst lengths and error pulses.
    always @(negedge clk) begin
        if (x_valid) begin
            samples.push_back(x_in);
            if (run == 0) first_xv_cyc = cyc;
            run++;
        end else if (run != 0) begin
            if (run != FL) bad_runs++;
            run = 0;
        end
        if (frame_err) begin
            err_cycles++;
            err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_if.s_data  = d;
        s_if.s_valid = 1'b1;
        s_if.s_last  = l;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (s_if.s_ready) ok = 1'b1;
            tick();
        end
        last_acc_cyc = cyc;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        check("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_frame(input int base);
        for (int k = 1; k <= FL; k++) send(DW'(base + k), (k == FL));
    endtask

    task automatic pulse_done();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
    endtask

    task automatic wait_samples(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (samples.size() >= n) ok = 1'b1;
        end
        check("wait_samples", 32'(ok), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int idx, input int base);
        for (int k = 0; k < FL; k++) check(tag, 32'(samples[idx + k]), 32'(base + k + 1));
    endtask

    initial begin
        s_if.s_data  = '0;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_x_in", 32'(x_in), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_s_ready", 32'(s_if.s_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Single frame 1,2,3,4 into an idle layer
        samples.delete();
        send_frame(0);
        wait_samples(4);
        repeat (2) tick();
        check("f1_count", 32'(samples.size()), 32'd4);
        check_frame("f1_data", 0, 0);
        check("f1_latency", 32'(first_xv_cyc - last_acc_cyc), 32'd2);
        check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("f1_burst_len", 32'(bad_runs), 32'd0);
        check("f1_no_err", 32'(err_cycles), 32'd0);
        repeat (3) tick();
        pulse_done();
        repeat (3) tick();

        // Three frames back to back with layer_done withheld
        samples.delete();
        send_frame(10);
        send_frame(20);
        @(negedge clk);
        check("bp_ready_low", 32'(s_if.s_ready), 32'd0);
        s_if.s_data  = 16'd31;
        s_if.s_valid = 1'b1;
        s_if.s_last  = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("bp_stalled", 32'(s_if.s_ready), 32'd0);
        check("bp_only_f1", 32'(samples.size()), 32'd4);
        tick();
        pulse_done();
        send_frame(30);
        wait_samples(8);
        repeat (12) tick();
        pulse_done();
        wait_samples(12);
        repeat (8) tick();
        pulse_done();
        repeat (3) tick();
        check("bp_count", 32'(samples.size()), 32'd12);
        check_frame("bp_f1", 0, 10);
        check_frame("bp_f2", 4, 20);
        check_frame("bp_f3", 8, 30);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd4);
        check("bp_burst_len", 32'(bad_runs), 32'd0);

        // Short frame followed by a good frame
        samples.delete();
        e0 = err_cycles;
        send(16'd9, 1'b0);
        send(16'd10, 1'b1);
        repeat (10) tick();
        check("short_err", 32'(err_cycles - e0), 32'd1);
        check("short_no_x", 32'(samples.size()), 32'd0);
        check("short_ready", 32'(s_if.s_ready), 32'd1);
        send_frame(4);
        wait_samples(4);
        repeat (2) tick();
        check_frame("short_next", 0, 4);
        check("short_next_err", 32'(err_cycles - e0), 32'd1);
        check("short_frame_cnt", 32'(frame_cnt), 32'd5);
        pulse_done();
        tick();

        // Long frame of 6 words
        samples.delete();
        e0 = err_cycles;
        send(16'd41, 1'b0);
        send(16'd42, 1'b0);
        send(16'd43, 1'b0);
        send(16'd44, 1'b0);
        acc4 = last_acc_cyc;
        send(16'd45, 1'b0);
        send(16'd46, 1'b1);
        repeat (10) tick();
        check("long_err", 32'(err_cycles - e0), 32'd1);
        check("long_err_at_w4", 32'(err_cyc - acc4), 32'd0);
        check("long_no_x", 32'(samples.size()), 32'd0);
        check("long_ready", 32'(s_if.s_ready), 32'd1);
        check("long_frame_cnt", 32'(frame_cnt), 32'd5);

        // Reset in the middle of a burst
        samples.delete();
        send_frame(50);
        wait_samples(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_x_valid", 32'(x_valid), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_ready", 32'(s_if.s_ready), 32'd1);
        check("mid_rst_count", 32'(samples.size()), 32'd2);
        tick();
        bad_runs = 0;
        samples.delete();
        send_frame(60);
        wait_samples(4);
        repeat (2) tick();
        check_frame("post_rst", 0, 60);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
        check("post_rst_burst_len", 32'(bad_runs), 32'd0);
        pulse_done();
        tick();

        // Last word into one bank and layer_done for the other bank in the same cycle
        samples.delete();
        send_frame(70);
        wait_samples(4);
        repeat (3) tick();
        send(16'd81, 1'b0);
        send(16'd82, 1'b0);
        send(16'd83, 1'b0);
        s_if.s_data  = 16'd84;
        s_if.s_last  = 1'b1;
        s_if.s_valid = 1'b1;
        layer_done   = 1'b1;
        @(negedge clk);
        check("same_cyc_ready", 32'(s_if.s_ready), 32'd1);
        tick();
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        layer_done   = 1'b0;
        wait_samples(8);
        repeat (3) tick();
        check("same_cyc_count", 32'(samples.size()), 32'd8);
        check_frame("same_cyc_a", 0, 70);
        check_frame("same_cyc_b", 4, 80);
        check("same_cyc_frame_cnt", 32'(frame_cnt), 32'd3);
        check("same_cyc_ready_after", 32'(s_if.s_ready), 32'd1);
        check("same_cyc_burst_len", 32'(bad_runs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
